pwm_compare_loader: RTL and testbench
=====================================

# pwm_compare_loader

Upstream staging stage for `PWMGenTop`: accepts per-phase compare writes over a valid/ready handshake into shadow registers, then commits all phases atomically on a carrier sync pulse so the PWM core never sees a half-updated set. Committed values are clamped to `PWMMaxCount` and drive `PWMGenTop`'s `Compare` array directly. A watchdog aborts a commit request that never sees a sync pulse.

## Interface
- `PhaseCount`, 3, number of phases / compare words.
- `BIT_WIDTH`, 16, width of compare, max-count and data words.
- `SyncTimeout`, 1024, cycles a commit request waits for `SyncPulse` before aborting (≥2).
- `MClk`  input  1  system clock, all logic on rising edge.
- `RstN`  input  1  asynchronous active-low reset.
- `WrValid`  input  1  write request.
- `WrReady`  output  1  loader can accept a write.
- `WrPhase`  input  $clog2(PhaseCount) (min 1)  target phase index.
- `WrData`  input  BIT_WIDTH  unsigned compare value.
- `CommitReq`  input  1  single-cycle request to commit shadow set.
- `SyncPulse`  input  1  one-cycle pulse at carrier zero/peak from the PWM core.
- `PWMMaxCount`  input  BIT_WIDTH  carrier peak, clamp limit.
- `ClearFlags`  input  1  clears sticky flags.
- `Compare`  output  BIT_WIDTH × [PhaseCount-1:0] unpacked  active compare values to `PWMGenTop`.
- `CommitDone`  output  1  one-cycle pulse, commit completed.
- `TimeoutErr`  output  1  one-cycle pulse, commit aborted.
- `ClampFlag`  output  1  sticky: a committed value was clamped.
- `PhaseErr`  output  1  sticky: write to phase index ≥ PhaseCount.

## Operation
- Reset: state IDLE; all `Compare` = 0; all shadow = 0; `WrReady`=0 while `RstN`=0, 1 from first edge after release; `CommitDone`, `TimeoutErr`, `ClampFlag`, `PhaseErr` = 0; timeout counter 0.
- States: IDLE, ARMED.
- IDLE: `WrReady`=1. Write accepted on edge with `WrValid && WrReady`; `shadow[WrPhase] <= WrData` (unclamped). `WrPhase` ≥ PhaseCount: write accepted (handshake completes), data dropped, `PhaseErr` set.
- IDLE, `CommitReq`=1 → ARMED, counter cleared. Write in same cycle is accepted and included in the commit.
- ARMED: `WrReady`=0; writes stall; `CommitReq` ignored. Counter increments each cycle.
  - `SyncPulse`=1 → for every phase `Compare[i] <= min(shadow[i], PWMMaxCount)`; if any clamped, set `ClampFlag`; `CommitDone` pulses next cycle; → IDLE.
  - Counter reaches `SyncTimeout-1` with no sync → `TimeoutErr` pulses, `Compare` unchanged, shadow retained, → IDLE.
  - `SyncPulse` on the timeout cycle: commit wins, no `TimeoutErr`.
- `SyncPulse` in IDLE: no effect.
- Clamp uses `PWMMaxCount` sampled on the commit edge; unsigned compare, equality not clamped.
- `ClearFlags` clears sticky flags; if a set condition occurs in the same cycle, set wins.
- Shadow persists across commits; uncommitted phases recommit their old shadow value.
- `RstN` asserted mid-ARMED: immediate return to reset values, pending commit discarded.

## Timing
- Write accepted on edge E; visible in shadow after E; no effect on `Compare` until commit.
- `CommitReq` sampled at edge C → ARMED after C; earliest commit on edge C+1 if `SyncPulse` high then (sync on C itself not used).
- Sync sampled at edge S → `Compare` and `ClampFlag` updated after S; `CommitDone` high for cycle S..S+1; `WrReady`=1 after S.
- Timeout: `TimeoutErr` high for one cycle, `SyncTimeout` cycles after ARMED entry.
- All outputs registered; no combinational path input→output except none (`WrReady` from state register).

## Test plan
- Reset: hold `RstN`=0 5 cycles mid-stimulus → `Compare`={0,0,0}, `WrReady`=0, flags 0; release → `WrReady`=1 next edge.
- Write 300/150/600 to phases 0/1/2, `PWMMaxCount`=500, `CommitReq`, `SyncPulse` 4 cycles later → `Compare`={300,150,500}, `ClampFlag`=1, one `CommitDone`; `Compare` unchanged before sync edge.
- Atomicity: ARMED with `WrValid` held, new 100 to phase 0 → `WrReady`=0, write stalls, completes after commit; committed phase 0 is old value, next commit gives 100.
- Timeout: `SyncTimeout`=16, `CommitReq`, no sync → `TimeoutErr` single pulse 16 cycles later, `Compare` unchanged; sync on exactly that cycle → commit, no error.
- Bad index: `WrPhase`=3 → handshake completes, shadow unchanged, `PhaseErr`=1; `ClearFlags` → 0; `ClearFlags` with simultaneous bad write → stays 1.
- Same-cycle write + `CommitReq` (phase 1 = 499, max 500) → commit includes 499, no clamp; value 500 → no clamp.

Source files
------------

// File: rtl/pwm_compare_loader.sv
// pwm_compare_loader
//
// Staging stage in front of the PWM core. Per-phase compare values arrive
// over a valid/ready write port and land in shadow registers. A commit
// request arms the loader; the next carrier sync pulse copies every shadow
// value (clamped to the carrier peak) into the active Compare set in a
// single edge, so the PWM core never sees a half-updated set. If no sync
// pulse arrives within SyncTimeout cycles the commit is abandoned.
//
// Ports:
//   MClk        system clock, rising edge
//   RstN        asynchronous active-low reset
//   WrValid     write request
//   WrReady     loader accepts writes (registered, low while armed)
//   WrPhase     target phase index
//   WrData      unsigned compare value (stored unclamped)
//   CommitReq   single-cycle request to commit the shadow set
//   SyncPulse   carrier zero/peak pulse from the PWM core
//   PWMMaxCount carrier peak, clamp limit sampled on the commit edge
//   ClearFlags  clears ClampFlag and PhaseErr (a same-cycle set wins)
//   Compare     active compare values, one per phase
//   CommitDone  one-cycle pulse after a commit
//   TimeoutErr  one-cycle pulse after an abandoned commit
//   ClampFlag   sticky: a committed value exceeded PWMMaxCount
//   PhaseErr    sticky: a write targeted a phase index >= PhaseCount
module pwm_compare_loader #(
  parameter int PhaseCount  = 3,
  parameter int BIT_WIDTH   = 16,
  parameter int SyncTimeout = 1024
) (
  input  logic                                                MClk,
  input  logic                                                RstN,
  input  logic                                                WrValid,
  output logic                                                WrReady,
  input  logic [(PhaseCount > 1 ? $clog2(PhaseCount) : 1)-1:0] WrPhase,
  input  logic [BIT_WIDTH-1:0]                                WrData,
  input  logic                                                CommitReq,
  input  logic                                                SyncPulse,
  input  logic [BIT_WIDTH-1:0]                                PWMMaxCount,
  input  logic                                                ClearFlags,
  output logic [BIT_WIDTH-1:0]                                Compare [PhaseCount-1:0],
  output logic                                                CommitDone,
  output logic                                                TimeoutErr,
  output logic                                                ClampFlag,
  output logic                                                PhaseErr
);

  localparam int PW = (PhaseCount > 1) ? $clog2(PhaseCount) : 1;
  localparam int CW = $clog2(SyncTimeout);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            wr_ready_reg;
  logic            commit_done_reg;
  logic            timeout_err_reg;
  logic            clamp_flag_reg;
  logic            phase_err_reg;

  logic                  wr_fire;
  logic                  phase_ok;
  logic                  commit_fire;
  logic                  timeout_fire;
  logic                  any_clamp;
  logic [PhaseCount-1:0] clamp_vec;

  // WrReady is only high in IDLE, so an accepted write never lands while armed.
  assign wr_fire      = WrValid && wr_ready_reg;
  assign phase_ok     = 32'(WrPhase) < 32'(PhaseCount);
  assign commit_fire  = (state_reg == ARMED) && SyncPulse;
  // A sync on the last waiting cycle takes priority over the timeout.
  assign timeout_fire = (state_reg == ARMED) && !SyncPulse &&
                        (cnt_reg == CW'(SyncTimeout - 1));
  assign any_clamp    = |clamp_vec;

  genvar gi;
  generate
    for (gi = 0; gi < PhaseCount; gi++) begin : g_phase
      logic [BIT_WIDTH-1:0] shadow_reg;
      logic [BIT_WIDTH-1:0] compare_reg;

      // Equality with the peak is a legal compare value, so only strictly
      // greater values are clamped.
      assign clamp_vec[gi] = shadow_reg > PWMMaxCount;

      always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
          shadow_reg  <= '0;
          compare_reg <= '0;
        end else begin
          if (wr_fire && phase_ok && (WrPhase == PW'(gi)))
            shadow_reg <= WrData;
          // Shadow is kept as written; clamping applies to the active copy only.
          if (commit_fire)
            compare_reg <= clamp_vec[gi] ? PWMMaxCount : shadow_reg;
        end
      end

      assign Compare[gi] = compare_reg;
    end
  endgenerate

  always_ff @(posedge MClk or negedge RstN) begin
    if (!RstN) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      wr_ready_reg    <= 1'b0;
      commit_done_reg <= 1'b0;
      timeout_err_reg <= 1'b0;
      clamp_flag_reg  <= 1'b0;
      phase_err_reg   <= 1'b0;
    end else begin
      commit_done_reg <= commit_fire;
      timeout_err_reg <= timeout_fire;

      case (state_reg)
        IDLE: begin
          if (CommitReq) begin
            state_reg    <= ARMED;
            cnt_reg      <= '0;
            wr_ready_reg <= 1'b0;
          end else begin
            wr_ready_reg <= 1'b1;
          end
        end
        ARMED: begin
          if (commit_fire || timeout_fire) begin
            state_reg    <= IDLE;
            wr_ready_reg <= 1'b1;
          end else begin
            cnt_reg      <= cnt_reg + 1'b1;
            wr_ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= IDLE;
          wr_ready_reg <= 1'b1;
        end
      endcase

      if (commit_fire && any_clamp)
        clamp_flag_reg <= 1'b1;
      else if (ClearFlags)
        clamp_flag_reg <= 1'b0;

      if (wr_fire && !phase_ok)
        phase_err_reg <= 1'b1;
      else if (ClearFlags)
        phase_err_reg <= 1'b0;
    end
  end

  assign WrReady    = wr_ready_reg;
  assign CommitDone = commit_done_reg;
  assign TimeoutErr = timeout_err_reg;
  assign ClampFlag  = clamp_flag_reg;
  assign PhaseErr   = phase_err_reg;

endmodule

// File: tb/tb_pwm_compare_loader.sv
// tb_pwm_compare_loader
//
// Directed scenarios followed by randomized traffic. A cycle-level
// behavioural model (plain arrays and a cycles-since-armed count) predicts
// every output; all outputs are compared on each falling edge.
module tb_pwm_compare_loader;

  localparam int PC = 3;
  localparam int BW = 16;
  localparam int TO = 16;

  logic          MClk = 1'b0;
  logic          RstN;
  logic          WrValid;
  logic          WrReady;
  logic [1:0]    WrPhase;
  logic [BW-1:0] WrData;
  logic          CommitReq;
  logic          SyncPulse;
  logic [BW-1:0] PWMMaxCount;
  logic          ClearFlags;
  logic [BW-1:0] Compare [PC-1:0];
  logic          CommitDone;
  logic          TimeoutErr;
  logic          ClampFlag;
  logic          PhaseErr;

  always #5 MClk = ~MClk;

  pwm_compare_loader #(
    .PhaseCount (PC),
    .BIT_WIDTH  (BW),
    .SyncTimeout(TO)
  ) dut (
    .MClk       (MClk),
    .RstN       (RstN),
    .WrValid    (WrValid),
    .WrReady    (WrReady),
    .WrPhase    (WrPhase),
    .WrData     (WrData),
    .CommitReq  (CommitReq),
    .SyncPulse  (SyncPulse),
    .PWMMaxCount(PWMMaxCount),
    .ClearFlags (ClearFlags),
    .Compare    (Compare),
    .CommitDone (CommitDone),
    .TimeoutErr (TimeoutErr),
    .ClampFlag  (ClampFlag),
    .PhaseErr   (PhaseErr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_shadow [PC];
  int m_cmp    [PC];
  bit m_armed;
  int m_waited;
  bit m_ready, m_done, m_terr, m_clamp, m_perr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < PC; i++) begin
      m_shadow[i] = 0;
      m_cmp[i]    = 0;
    end
    m_armed = 0; m_waited = 0;
    m_ready = 0; m_done = 0; m_terr = 0; m_clamp = 0; m_perr = 0;
  endfunction

  // One rising edge worth of behaviour, from the inputs present at that edge.
  function automatic void model_step();
    bit clamp_set = 0;
    bit perr_set  = 0;
    m_done = 0;
    m_terr = 0;
    if (!m_armed) begin
      if (WrValid && m_ready) begin
        if (int'(WrPhase) < PC) m_shadow[WrPhase] = int'(WrData);
        else perr_set = 1;
      end
      if (CommitReq) begin
        m_armed  = 1;
        m_waited = 0;
      end
    end else begin
      m_waited++;
      if (SyncPulse) begin
        for (int i = 0; i < PC; i++) begin
          if (m_shadow[i] > int'(PWMMaxCount)) begin
            m_cmp[i]  = int'(PWMMaxCount);
            clamp_set = 1;
          end else begin
            m_cmp[i] = m_shadow[i];
          end
        end
        m_done  = 1;
        m_armed = 0;
      end else if (m_waited == TO) begin
        m_terr  = 1;
        m_armed = 0;
      end
    end
    m_clamp = clamp_set ? 1'b1 : (ClearFlags ? 1'b0 : m_clamp);
    m_perr  = perr_set  ? 1'b1 : (ClearFlags ? 1'b0 : m_perr);
    m_ready = !m_armed;
  endfunction

  task automatic check_all();
    chk("wr_ready",    32'(WrReady),    32'(m_ready));
    chk("commit_done", 32'(CommitDone), 32'(m_done));
    chk("timeout_err", 32'(TimeoutErr), 32'(m_terr));
    chk("clamp_flag",  32'(ClampFlag),  32'(m_clamp));
    chk("phase_err",   32'(PhaseErr),   32'(m_perr));
    for (int i = 0; i < PC; i++)
      chk($sformatf("compare[%0d]", i), 32'(Compare[i]), m_cmp[i]);
  endtask

  task automatic tick();
    @(posedge MClk);
    if (RstN) model_step();
    @(negedge MClk);
    check_all();
  endtask

  task automatic drive(input bit v, input int ph, input int d, input bit cr, input bit sp, input bit cf);
    WrValid    = v;
    WrPhase    = 2'(ph);
    WrData     = BW'(d);
    CommitReq  = cr;
    SyncPulse  = sp;
    ClearFlags = cf;
  endtask

  task automatic step(input bit v, input int ph, input int d, input bit cr, input bit sp, input bit cf);
    drive(v, ph, d, cr, sp, cf);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    RstN = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < n; i++) tick();
    RstN = 1'b1;
  endtask

  initial begin
    RstN        = 1'b0;
    PWMMaxCount = 16'd500;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge MClk);
    do_reset(3);
    idle(1);
    chk("ready_after_release", 32'(WrReady), 32'd1);

    // Basic commit with clamp; sync arrives 4 cycles after the request.
    step(1, 0, 300, 0, 0, 0);
    step(1, 1, 150, 0, 0, 0);
    step(1, 2, 600, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(3);
    chk("cmp0_before_sync", 32'(Compare[0]), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("commit_cmp0", 32'(Compare[0]), 32'd300);
    chk("commit_cmp1", 32'(Compare[1]), 32'd150);
    chk("commit_cmp2", 32'(Compare[2]), 32'd500);
    chk("commit_clamp", 32'(ClampFlag), 32'd1);
    chk("commit_done", 32'(CommitDone), 32'd1);
    idle(1);
    chk("commit_done_single", 32'(CommitDone), 32'd0);

    // Atomicity: a write held during ARMED stalls until after the commit.
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 100, 0, 0, 0);
    chk("armed_not_ready", 32'(WrReady), 32'd0);
    step(1, 0, 100, 0, 0, 0);
    step(1, 0, 100, 0, 1, 0);
    chk("atomic_old_cmp0", 32'(Compare[0]), 32'd300);
    step(1, 0, 100, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("atomic_new_cmp0", 32'(Compare[0]), 32'd100);

    // Timeout: no sync for TO cycles.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    idle(TO - 1);
    chk("timeout_not_early", 32'(TimeoutErr), 32'd0);
    idle(1);
    chk("timeout_pulse", 32'(TimeoutErr), 32'd1);
    chk("timeout_cmp0_kept", 32'(Compare[0]), 32'd100);
    idle(1);
    chk("timeout_single", 32'(TimeoutErr), 32'd0);
    // Sync exactly on the timeout edge: commit wins.
    step(0, 0, 0, 1, 0, 0);
    idle(TO - 1);
    step(0, 0, 0, 0, 1, 0);
    chk("late_sync_done", 32'(CommitDone), 32'd1);
    chk("late_sync_no_err", 32'(TimeoutErr), 32'd0);

    // Bad phase index.
    step(1, 3, 777, 0, 0, 1);
    chk("bad_phase_err", 32'(PhaseErr), 32'd1);
    chk("bad_phase_ready", 32'(WrReady), 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("phase_err_cleared", 32'(PhaseErr), 32'd0);
    step(1, 3, 5, 0, 0, 1);
    chk("phase_err_set_wins", 32'(PhaseErr), 32'd1);

    // Same-cycle write + commit; values at or under the peak do not clamp.
    PWMMaxCount = 16'd500;
    step(1, 2, 200, 0, 0, 1);
    step(1, 1, 499, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("same_cycle_cmp1", 32'(Compare[1]), 32'd499);
    chk("same_cycle_noclamp", 32'(ClampFlag), 32'd0);
    step(1, 1, 500, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("equal_cmp1", 32'(Compare[1]), 32'd500);
    chk("equal_noclamp", 32'(ClampFlag), 32'd0);

    // Reset in the middle of an armed commit.
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    do_reset(5);
    chk("reset_cmp1", 32'(Compare[1]), 32'd0);
    idle(1);
    chk("reset_ready_again", 32'(WrReady), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) PWMMaxCount = BW'($urandom_range(200, 900));
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2);
      end else begin
        step($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 1023)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
